piso_serializer: RTL and testbench

- Parallel-in, serial-out shift register: the transmit-side counterpart of the team's serial-in shift register (SR).
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Drives a serial bit, a bit-valid strobe and a last-bit marker; output can feed SR's x_i directly.
- Supports back-to-back words with no idle cycle between frames.

---
 rtl/piso_serializer_if.sv | 21 ++
 rtl/piso_serializer.sv | 104 ++++++++++
 tb/tb_piso_serializer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel word handshake and serial output bundle for piso_serializer
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             par_vld_i;
    logic [WIDTH-1:0] par_data_i;
    logic             par_rdy_o;
    logic             ser_o;
    logic             ser_vld_o;
    logic             ser_last_o;

    modport master (
        output par_vld_i, par_data_i,
        input  par_rdy_o, ser_o, ser_vld_o, ser_last_o
    );

    modport slave (
        input  par_vld_i, par_data_i,
        output par_rdy_o, ser_o, ser_vld_o, ser_last_o
    );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter; PISO_PARITY_EN appends an even parity bit
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    piso_serializer_if.slave  bus
);
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int            CW     = $clog2(FRAME + 1);
    localparam logic [CW-1:0] C_LAST = CW'(FRAME);
    localparam logic [CW-1:0] C_PEN  = CW'(FRAME - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    logic [FRAME-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_ser;
    logic             r_vld;
    logic             r_last;

    logic [FRAME-1:0] w_load;
    logic             w_rdy;
    logic             w_accept;

    // Load image is arranged so the parity bit always leaves after the data bits.
    always_comb begin
`ifdef PISO_PARITY_EN
        w_load = MSB_FIRST ? {bus.par_data_i, ^bus.par_data_i}
                           : {^bus.par_data_i, bus.par_data_i};
`else
        w_load = bus.par_data_i;
`endif
    end

    function automatic logic f_head(input logic [FRAME-1:0] x);
        return MSB_FIRST ? x[FRAME-1] : x[0];
    endfunction

    function automatic logic [FRAME-1:0] f_tail(input logic [FRAME-1:0] x);
        return MSB_FIRST ? {x[FRAME-2:0], 1'b0} : {1'b0, x[FRAME-1:1]};
    endfunction

    // r_last is only ever set in SHIFT, so it marks the back-to-back window.
    assign w_rdy    = (r_state == IDLE) || r_last;
    assign w_accept = bus.par_vld_i && w_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_ser   <= 1'b0;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_shift <= w_load;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (r_cnt == C_LAST) begin
                        if (w_accept) begin
                            // Next word bypasses the load cycle so the stream has no gap.
                            r_ser   <= f_head(w_load);
                            r_shift <= f_tail(w_load);
                            r_cnt   <= CW'(1);
                            r_vld   <= 1'b1;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_shift <= '0;
                            r_cnt   <= '0;
                            r_ser   <= 1'b0;
                            r_vld   <= 1'b0;
                            r_last  <= 1'b0;
                        end
                    end else begin
                        r_ser   <= f_head(r_shift);
                        r_shift <= f_tail(r_shift);
                        r_cnt   <= r_cnt + CW'(1);
                        r_vld   <= 1'b1;
                        r_last  <= (r_cnt == C_PEN);
                    end
                end
            endcase
        end
    end

    assign bus.par_rdy_o  = w_rdy;
    assign bus.ser_o      = r_ser;
    assign bus.ser_vld_o  = r_vld;
    assign bus.ser_last_o = r_last;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed bench for piso_serializer, MSB-first and LSB-first instances
module tb_piso_serializer;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int F = W + 1;
    localparam logic [F-1:0] E_B_M  = 5'b10111, E_B_L  = 5'b11011;
    localparam logic [F-1:0] E_A_M  = 5'b10100, E_A_L  = 5'b01010;
    localparam logic [F-1:0] E_5_M  = 5'b01010, E_5_L  = 5'b10100;
    localparam logic [F-1:0] E_C_M  = 5'b11000, E_C_L  = 5'b00110;
    localparam logic [F-1:0] E_3_M  = 5'b00110, E_3_L  = 5'b11000;
    localparam logic [F-1:0] E_6_M  = 5'b01100, E_6_L  = 5'b01100;
`else
    localparam int F = W;
    localparam logic [F-1:0] E_B_M  = 4'b1011, E_B_L  = 4'b1101;
    localparam logic [F-1:0] E_A_M  = 4'b1010, E_A_L  = 4'b0101;
    localparam logic [F-1:0] E_5_M  = 4'b0101, E_5_L  = 4'b1010;
    localparam logic [F-1:0] E_C_M  = 4'b1100, E_C_L  = 4'b0011;
    localparam logic [F-1:0] E_3_M  = 4'b0011, E_3_L  = 4'b1100;
    localparam logic [F-1:0] E_6_M  = 4'b0110, E_6_L  = 4'b0110;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         vld;
    logic [W-1:0] data;
    int           n_checks = 0;
    int           n_fail   = 0;

    piso_serializer_if #(.WIDTH(W)) bus_m ();
    piso_serializer_if #(.WIDTH(W)) bus_l ();

    assign bus_m.par_vld_i  = vld;
    assign bus_m.par_data_i = data;
    assign bus_l.par_vld_i  = vld;
    assign bus_l.par_data_i = data;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(bus_m));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(bus_l));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input int i, input logic [F-1:0] em, input logic [F-1:0] el);
        check($sformatf("%s_ser_m%0d", tag, i), bus_m.ser_o, em[F-1-i]);
        check($sformatf("%s_ser_l%0d", tag, i), bus_l.ser_o, el[F-1-i]);
        check($sformatf("%s_vld%0d", tag, i), bus_m.ser_vld_o, 1'b1);
        check($sformatf("%s_last%0d", tag, i), bus_m.ser_last_o, (i == F-1));
        check($sformatf("%s_rdy%0d", tag, i), bus_m.par_rdy_o, (i == F-1));
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_vld_m"}, bus_m.ser_vld_o, 1'b0);
        check({tag, "_vld_l"}, bus_l.ser_vld_o, 1'b0);
        check({tag, "_ser"}, bus_m.ser_o, 1'b0);
        check({tag, "_last"}, bus_m.ser_last_o, 1'b0);
        check({tag, "_rdy"}, bus_m.par_rdy_o, 1'b1);
    endtask

    task automatic run_single(input string tag, input logic [W-1:0] word,
                              input logic [F-1:0] em, input logic [F-1:0] el);
        vld  = 1'b1;
        data = word;
        tick();
        vld = 1'b0;
        check({tag, "_gap_vld"}, bus_m.ser_vld_o, 1'b0);
        check({tag, "_gap_rdy"}, bus_m.par_rdy_o, 1'b0);
        tick();
        for (int i = 0; i < F; i++) begin
            chk_bit(tag, i, em, el);
            tick();
        end
        chk_idle({tag, "_end"});
    endtask

    initial begin
        reset = 1'b0;
        vld   = 1'b0;
        data  = 4'hB;
        for (int k = 0; k < 3; k++) begin
            tick();
            vld = ~vld;
            chk_idle($sformatf("rst%0d", k));
        end
        vld = 1'b0;
        reset = 1'b1;
        tick();
        chk_idle("rst_rel");

        run_single("single", 4'hB, E_B_M, E_B_L);

        // Back-to-back: word 5 replaces A only once the last bit of A is out.
        vld  = 1'b1;
        data = 4'hA;
        tick();
        tick();
        for (int i = 0; i < F; i++) begin
            chk_bit("b2b_a", i, E_A_M, E_A_L);
            if (i == F-1) data = 4'h5;
            tick();
        end
        vld = 1'b0;
        for (int i = 0; i < F; i++) begin
            chk_bit("b2b_5", i, E_5_M, E_5_L);
            tick();
        end
        chk_idle("b2b_end");

        // Offers made while busy must not disturb the frame in flight.
        vld  = 1'b1;
        data = 4'hC;
        tick();
        vld = 1'b0;
        tick();
        for (int i = 0; i < F; i++) begin
            chk_bit("stall_c", i, E_C_M, E_C_L);
            if (i == 1) begin
                vld  = 1'b1;
                data = 4'hF;
            end
            if (i == 2) data = 4'h3;
            tick();
        end
        vld = 1'b0;
        for (int i = 0; i < F; i++) begin
            chk_bit("stall_3", i, E_3_M, E_3_L);
            tick();
        end
        chk_idle("stall_end");

        vld  = 1'b1;
        data = 4'hF;
        tick();
        vld = 1'b0;
        tick();
        chk_bit("abort", 0, {F{1'b1}}, {F{1'b1}});
        tick();
        chk_bit("abort", 1, {F{1'b1}}, {F{1'b1}});
        #2;
        reset = 1'b0;
        #1;
        chk_idle("abort_async");
        tick();
        reset = 1'b1;
        tick();
        chk_idle("abort_rel");
        run_single("after", 4'h6, E_6_M, E_6_L);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
